// File: rtl/johnson_phase_pkg.sv
// Shared types and helpers for the Johnson ring phase monitor.
// Optional build macro consumed by the top: JOHNSON_PHASE_MONITOR_SYNC_EN.
package johnson_phase_pkg;

  localparam int unsigned MaxStages = 32;
  localparam int unsigned CntWidth  = 4;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StLocking  = 2'd1,
    StLocked   = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    TrAdv  = 2'd0,
    TrHold = 2'd1,
    TrBad  = 2'd2
  } trans_e;

  // Code k of an n-stage ring: k ones filling from bit 0, then zeros filling from bit 0.
  function automatic logic [MaxStages-1:0] johnson_encode(input int unsigned k,
                                                          input int unsigned n);
    logic [MaxStages-1:0] code;
    code = '0;
    for (int unsigned b = 0; b < MaxStages; b++) begin
      if (b < n) begin
        if (k <= n) code[b] = (b < k);
        else        code[b] = (b >= k - n);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of an N-bit Johnson ring state into (legal, phase index).
module johnson_decode
  import johnson_phase_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(2 * N)
) (
  input  logic [N-1:0]    code_i,
  output logic            legal_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    legal_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < 2 * N; k++) begin
      if (MaxStages'(code_i) == johnson_encode(k, N)) begin
        legal_o = 1'b1;
        idx_o   = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson ring phase monitor: decode, successor check, lock FSM, revolution count, sticky error.
// Define JOHNSON_PHASE_MONITOR_SYNC_EN to insert a two-flop synchroniser ahead of stage 1.
module johnson_phase_monitor
  import johnson_phase_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned REV_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [N-1:0]         I,
  output logic [2*N-1:0]       PHASE,
  output logic                 LOCKED,
  output logic                 WRAP,
  output logic [REV_WIDTH-1:0] REV,
  output logic                 ERR,
  input  logic                 ERR_CLR
);

  localparam int unsigned Phases = 2 * N;
  localparam int unsigned IdxW   = $clog2(Phases);
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(Phases - 1);
  localparam logic [CntWidth-1:0] LockCnt = CntWidth'(LOCK_COUNT);

  logic [N-1:0] stage_in;
  logic [N-1:0] s1_q;

`ifdef JOHNSON_PHASE_MONITOR_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= I;
      sync2_q <= sync1_q;
    end
  end

  assign stage_in = sync2_q;
`else
  assign stage_in = I;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) s1_q <= '0;
    else         s1_q <= stage_in;
  end

  logic            legal;
  logic [IdxW-1:0] idx;

  johnson_decode #(
    .N    (N),
    .IdxW (IdxW)
  ) u_decode (
    .code_i  (s1_q),
    .legal_o (legal),
    .idx_o   (idx)
  );

  lock_state_e            state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]        prev_idx_q, prev_idx_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [Phases-1:0]      phase_q, phase_d;
  logic                   wrap_q, wrap_d;
  logic [REV_WIDTH-1:0]   rev_q, rev_d;
  logic                   err_q, err_d;
  logic [IdxW-1:0]        adv_idx;
  trans_e                 trans;

  assign adv_idx = (prev_idx_q == LastIdx) ? '0 : prev_idx_q + 1'b1;

  // The first legal code after reset or an illegal code only seeds prev; treat it as HOLD.
  always_comb begin
    trans = TrBad;
    if (legal) begin
      if (!prev_valid_q || idx == prev_idx_q) trans = TrHold;
      else if (idx == adv_idx)                trans = TrAdv;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StUnlocked, StLocking: begin
        if (trans == TrAdv) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d >= LockCnt) ? StLocked : StLocking;
        end else if (trans == TrBad) begin
          state_d = StUnlocked;
          cnt_d   = '0;
        end
      end
      StLocked: begin
        if (trans == TrBad) begin
          state_d = StUnlocked;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StUnlocked;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    prev_idx_d   = legal ? idx : prev_idx_q;
    prev_valid_d = legal;
    phase_d      = '0;
    if (state_d == StLocked && legal) begin
      phase_d = {{(Phases - 1){1'b0}}, 1'b1} << idx;
    end
    wrap_d = (state_d == StLocked) && (trans == TrAdv) && (idx == '0);
    rev_d  = rev_q + REV_WIDTH'(wrap_d);
    // A violation in the same cycle as a clear request keeps the flag set.
    err_d  = ERR_CLR ? 1'b0 : err_q;
    if (state_q == StLocked && trans == TrBad) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= StUnlocked;
      cnt_q        <= '0;
      prev_idx_q   <= '0;
      prev_valid_q <= 1'b0;
      phase_q      <= '0;
      wrap_q       <= 1'b0;
      rev_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_idx_q   <= prev_idx_d;
      prev_valid_q <= prev_valid_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
      rev_q        <= rev_d;
      err_q        <= err_d;
    end
  end

  assign PHASE  = phase_q;
  assign LOCKED = (state_q == StLocked);
  assign WRAP   = wrap_q;
  assign REV    = rev_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomised bench: an N=2 and an N=3 monitor share clock/reset, checked against a streak model.
module tb_johnson_phase_monitor;

  localparam int unsigned NA  = 2;
  localparam int unsigned NB  = 3;
  localparam int unsigned LC  = 4;
  localparam int unsigned RWA = 8;
  localparam int unsigned RWB = 2;
`ifdef JOHNSON_PHASE_MONITOR_SYNC_EN
  localparam int Delay = 3;
`else
  localparam int Delay = 1;
`endif

  localparam int ActAdv     = 0;
  localparam int ActHold    = 1;
  localparam int ActSkip    = 2;
  localparam int ActRand    = 3;
  localparam int ActIllegal = 4;

  logic              clk;
  logic              rst_n;
  logic              err_clr;
  logic [NA-1:0]     i_a;
  logic [NB-1:0]     i_b;
  logic [2*NA-1:0]   phase_a;
  logic [2*NB-1:0]   phase_b;
  logic              locked_a, locked_b, wrap_a, wrap_b, err_a, err_b;
  logic [RWA-1:0]    rev_a;
  logic [RWB-1:0]    rev_b;

  johnson_phase_monitor #(
    .N          (NA),
    .LOCK_COUNT (LC),
    .REV_WIDTH  (RWA)
  ) u_dut_a (
    .CLK     (clk),
    .RESETN  (rst_n),
    .I       (i_a),
    .PHASE   (phase_a),
    .LOCKED  (locked_a),
    .WRAP    (wrap_a),
    .REV     (rev_a),
    .ERR     (err_a),
    .ERR_CLR (err_clr)
  );

  johnson_phase_monitor #(
    .N          (NB),
    .LOCK_COUNT (LC),
    .REV_WIDTH  (RWB)
  ) u_dut_b (
    .CLK     (clk),
    .RESETN  (rst_n),
    .I       (i_b),
    .PHASE   (phase_b),
    .LOCKED  (locked_b),
    .WRAP    (wrap_b),
    .REV     (rev_b),
    .ERR     (err_b),
    .ERR_CLR (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: lock = at least LC advances since the last bad transition.
  int m_prev[2], m_pvalid[2], m_streak[2], m_locked[2];
  int m_err[2], m_rev[2], m_phase[2], m_wrap[2];
  int hist[2][4];
  int gpos[2];

  function automatic int n_of(input int u);
    return (u == 0) ? int'(NA) : int'(NB);
  endfunction

  function automatic int rw_of(input int u);
    return (u == 0) ? int'(RWA) : int'(RWB);
  endfunction

  function automatic int enc(input int n, input int k);
    if (k <= n) return (1 << k) - 1;
    return ((1 << n) - 1) & ~((1 << (k - n)) - 1);
  endfunction

  function automatic int dec(input int n, input int code);
    int pc;
    pc = $countones(code);
    if (code == (1 << pc) - 1) return pc;
    if (pc > 0 && pc < n && code == enc(n, 2 * n - pc)) return 2 * n - pc;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_prev[u] = 0;  m_pvalid[u] = 0; m_streak[u] = 0; m_locked[u] = 0;
      m_err[u]  = 0;  m_rev[u]    = 0; m_phase[u]  = 0; m_wrap[u]   = 0;
      for (int j = 0; j < 4; j++) hist[u][j] = 0;
    end
  endtask

  task automatic model_step(input int u, input int code, input bit clr);
    int n, idx;
    bit bad, adv;
    n   = n_of(u);
    idx = dec(n, code);
    bad = 1'b0;
    adv = 1'b0;
    if (idx < 0) bad = 1'b1;
    else if (m_pvalid[u] != 0) begin
      if (idx == (m_prev[u] + 1) % (2 * n)) adv = 1'b1;
      else if (idx != m_prev[u])            bad = 1'b1;
    end
    if (clr) m_err[u] = 0;
    m_wrap[u] = 0;
    if (bad) begin
      if (m_locked[u] != 0) m_err[u] = 1;
      m_locked[u] = 0;
      m_streak[u] = 0;
    end
    if (adv) begin
      m_streak[u]++;
      if (m_streak[u] >= int'(LC)) m_locked[u] = 1;
      if (m_locked[u] != 0 && idx == 0) begin
        m_wrap[u] = 1;
        m_rev[u]  = (m_rev[u] + 1) % (1 << rw_of(u));
      end
    end
    m_phase[u] = (m_locked[u] != 0 && idx >= 0) ? (1 << idx) : 0;
    if (idx >= 0) m_prev[u] = idx;
    m_pvalid[u] = (idx >= 0) ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0, hist[0][Delay-1], err_clr);
        model_step(1, hist[1][Delay-1], err_clr);
        for (int j = 3; j > 0; j--) begin
          hist[0][j] = hist[0][j-1];
          hist[1][j] = hist[1][j-1];
        end
        hist[0][0] = int'(i_a);
        hist[1][0] = int'(i_b);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("A.phase",  32'(phase_a),  32'(m_phase[0]));
        chk("A.locked", 32'(locked_a), 32'(m_locked[0]));
        chk("A.wrap",   32'(wrap_a),   32'(m_wrap[0]));
        chk("A.rev",    32'(rev_a),    32'(m_rev[0]));
        chk("A.err",    32'(err_a),    32'(m_err[0]));
        chk("B.phase",  32'(phase_b),  32'(m_phase[1]));
        chk("B.locked", 32'(locked_b), 32'(m_locked[1]));
        chk("B.wrap",   32'(wrap_b),   32'(m_wrap[1]));
        chk("B.rev",    32'(rev_b),    32'(m_rev[1]));
        chk("B.err",    32'(err_b),    32'(m_err[1]));
      end
    end
  end

  function automatic int next_code(input int u, input int act);
    int n, c, d;
    n = n_of(u);
    case (act)
      ActAdv:  gpos[u] = (gpos[u] + 1) % (2 * n);
      ActSkip: gpos[u] = (gpos[u] + 2) % (2 * n);
      ActRand: begin
        c = int'($urandom_range(0, (1 << n) - 1));
        d = dec(n, c);
        if (d >= 0) gpos[u] = d;
        return c;
      end
      ActIllegal: if (n >= 3) return 2;
      default: ;
    endcase
    return enc(n, gpos[u]);
  endfunction

  task automatic drive(input int act0, input int act1, input bit clr);
    @(negedge clk);
    i_a     = NA'(next_code(0, act0));
    i_b     = NB'(next_code(1, act1));
    err_clr = clr;
  endtask

  function automatic int rand_act(input int u);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 2)  return (u == 1) ? ActIllegal : ActRand;
    if (r < 4)  return ActSkip;
    if (r < 6)  return ActRand;
    if (r < 25) return ActHold;
    return ActAdv;
  endfunction

  initial begin
    rst_n   = 1'b0;
    err_clr = 1'b0;
    i_a     = '0;
    i_b     = '0;
    gpos[0] = 0;
    gpos[1] = 0;
    chk_en  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean advance: lock, then several revolutions (B's 2-bit REV wraps)
    repeat (6 * 6 + 4) drive(ActAdv, ActAdv, 1'b0);
    // Skip on A, illegal code on B while locked
    drive(ActSkip, ActIllegal, 1'b0);
    repeat (4) drive(ActHold, ActHold, 1'b0);
    // Re-lock with ERR still set, then clear it
    repeat (10) drive(ActAdv, ActAdv, 1'b0);
    drive(ActAdv, ActAdv, 1'b1);
    repeat (3) drive(ActAdv, ActAdv, 1'b0);
    // Long hold while locked, then resume
    repeat (5) drive(ActHold, ActHold, 1'b0);
    repeat (6) drive(ActAdv, ActAdv, 1'b0);
    // Violation together with a clear request
    drive(ActSkip, ActIllegal, 1'b0);
    drive(ActHold, ActHold, 1'b1);
    repeat (4) drive(ActHold, ActHold, 1'b0);

    // Random mixture
    for (int c = 0; c < 3000; c++) begin
      drive(rand_act(0), rand_act(1), ($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset between edges while locked
    repeat (20) drive(ActAdv, ActAdv, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.A.locked", 32'(locked_a), 32'd0);
    chk("rst.A.phase",  32'(phase_a),  32'd0);
    chk("rst.A.rev",    32'(rev_a),    32'd0);
    chk("rst.A.wrap",   32'(wrap_a),   32'd0);
    chk("rst.B.locked", 32'(locked_b), 32'd0);
    chk("rst.B.phase",  32'(phase_b),  32'd0);
    chk("rst.B.err",    32'(err_b),    32'd0);
    @(negedge clk);
    gpos[0] = 0;
    gpos[1] = 0;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) drive(ActAdv, ActAdv, 1'b0);
    repeat (40) drive(rand_act(0), rand_act(1), 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
